// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   MDUOp_* : 4-bit operation codes used by the decoder and the MDU.
//   mdu_state_e : FSM state encoding (IDLE / RUN).
//   md_res_t / md_calc : one-shot product/quotient calculation used to
//                        fill the temp result register at the accepting edge.
package mdu_pkg;

  localparam logic [3:0] MDUOp_MULT  = 4'd0;
  localparam logic [3:0] MDUOp_MULTU = 4'd1;
  localparam logic [3:0] MDUOp_DIV   = 4'd2;
  localparam logic [3:0] MDUOp_DIVU  = 4'd3;
  localparam logic [3:0] MDUOp_MTHI  = 4'd4;
  localparam logic [3:0] MDUOp_MTLO  = 4'd5;
  localparam logic [3:0] MDUOp_NONE  = 4'd15;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  // we=0 means HI/LO must be left untouched at completion (divide by zero).
  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_res_t;

  function automatic md_res_t md_calc(input logic [3:0]  op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    md_res_t            res;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sda;
    logic signed [31:0] sdb;
    res = '{we: 1'b0, hi: 32'h0000_0000, lo: 32'h0000_0000};
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sp  = 64'sh0;
    up  = 64'h0;
    sda = a;
    sdb = b;
    case (op)
      MDUOp_MULT: begin
        sp     = sa * sb;
        res.we = 1'b1;
        res.hi = sp[63:32];
        res.lo = sp[31:0];
      end
      MDUOp_MULTU: begin
        up     = {32'h0000_0000, a} * {32'h0000_0000, b};
        res.we = 1'b1;
        res.hi = up[63:32];
        res.lo = up[31:0];
      end
      MDUOp_DIV: begin
        if (b == 32'h0000_0000) begin
          res.we = 1'b0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // Quotient overflows; architecturally wraps to the dividend.
          res.we = 1'b1;
          res.hi = 32'h0000_0000;
          res.lo = 32'h8000_0000;
        end else begin
          // SV signed / truncates toward zero; % takes the dividend's sign.
          res.we = 1'b1;
          res.lo = sda / sdb;
          res.hi = sda % sdb;
        end
      end
      MDUOp_DIVU: begin
        if (b == 32'h0000_0000) begin
          res.we = 1'b0;
        end else begin
          res.we = 1'b1;
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: begin
        res.we = 1'b0;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if -- request/result bundle between the EX stage and the MDU.
//   start/req/MDUOp/A/B : request from the pipeline (master drives).
//   busy/HI/LO          : registered status and architectural HI/LO (slave drives).
interface mdu_if;
  logic        start;
  logic        req;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, req, MDUOp, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, req, MDUOp, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit holding the HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (IDLE, counter 0, busy/HI/LO = 0)
//   bus   : mdu_if.slave -- start/req/MDUOp/A/B in, busy/HI/LO out
// mult/div results are computed at the accepting edge into a temp register and
// copied to HI/LO only when the busy window ends, so HI/LO stay stable in RUN.
// mthi/mtlo write HI/LO directly at the accepting edge without entering RUN.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.slave   bus
);

  mdu_state_e  r_state;
  mdu_state_e  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [63:0] r_tmp;
  logic        r_tmp_we;
  logic        w_load_tmp;
  logic        w_accept;
  md_res_t     w_calc;

  assign w_calc   = md_calc(bus.MDUOp, bus.A, bus.B);
  // req (exception/interrupt) cancels the request; start in RUN is ignored.
  assign w_accept = bus.start & ~bus.req & (r_state == S_IDLE);

  assign bus.busy = r_busy;
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;

  // Next-state, counter, busy and HI/LO write decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_load_tmp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = 4'd0;
        w_busy_nxt = 1'b0;
        if (w_accept) begin
          case (bus.MDUOp)
            MDUOp_MULT, MDUOp_MULTU: begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = 4'(MULT_CYCLES);
              w_busy_nxt  = 1'b1;
              w_load_tmp  = 1'b1;
            end
            MDUOp_DIV, MDUOp_DIVU: begin
              w_state_nxt = S_RUN;
              w_cnt_nxt   = 4'(DIV_CYCLES);
              w_busy_nxt  = 1'b1;
              w_load_tmp  = 1'b1;
            end
            MDUOp_MTHI: begin
              w_hi_nxt = bus.A;
            end
            MDUOp_MTLO: begin
              w_lo_nxt = bus.A;
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // Counter value 1 marks the last busy cycle: commit and drop busy.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
          w_busy_nxt  = 1'b0;
          if (r_tmp_we) begin
            w_hi_nxt = r_tmp[63:32];
            w_lo_nxt = r_tmp[31:0];
          end else begin
            w_hi_nxt = r_hi;
            w_lo_nxt = r_lo;
          end
        end else begin
          w_cnt_nxt  = r_cnt - 4'd1;
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state, cycle counter and registered busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Temp result captured at the accepting edge of mult/div.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmp    <= 64'h0;
      r_tmp_we <= 1'b0;
    end else if (w_load_tmp) begin
      r_tmp    <= {w_calc.hi, w_calc.lo};
      r_tmp_we <= w_calc.we;
    end else begin
      r_tmp    <= r_tmp;
      r_tmp_we <= r_tmp_we;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 32'h0000_0000;
      r_lo <= 32'h0000_0000;
    end else begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- self-checking bench for mdu: directed cases from the test plan
// followed by random operations compared against a 64-bit arithmetic model.
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_if bus ();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural effect of one accepted request on HI/LO.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (op == MDUOp_MULT) begin
      q  = sa * sb;
      hi = q[63:32];
      lo = q[31:0];
    end else if (op == MDUOp_MULTU) begin
      p  = ua * ub;
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == MDUOp_DIV && b != 32'd0) begin
      q  = sa / sb;
      r  = sa - q * sb;
      hi = r[31:0];
      lo = q[31:0];
    end else if (op == MDUOp_DIVU && b != 32'd0) begin
      hi = a % b;
      lo = a / b;
    end else if (op == MDUOp_MTHI) begin
      hi = a;
    end else if (op == MDUOp_MTLO) begin
      lo = a;
    end
  endfunction

  // Issue one request, check busy for the whole window and HI/LO stability,
  // then check the final HI/LO. poke=1 fires an extra start while RUN.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] ehi, elo;
    int n;
    ehi = m_hi;
    elo = m_lo;
    model(op, a, b, ehi, elo);
    if (op == MDUOp_MULT || op == MDUOp_MULTU) n = 5;
    else if (op == MDUOp_DIV || op == MDUOp_DIVU) n = 10;
    else n = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.req = 1'b0; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    for (int i = 0; i < n; i++) begin
      check32("busy_run", {31'd0, bus.busy}, 32'd1);
      check32("hi_stable", bus.HI, m_hi);
      check32("lo_stable", bus.LO, m_lo);
      if (poke && i == 1) begin
        bus.start = 1'b1; bus.MDUOp = MDUOp_MTLO; bus.A = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check32("busy_done", {31'd0, bus.busy}, 32'd0);
    check32("hi_result", bus.HI, ehi);
    check32("lo_result", bus.LO, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          sel;
    checks = 0; failures = 0; m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1;
    bus.start = 1'b0; bus.req = 1'b0; bus.MDUOp = MDUOp_NONE;
    bus.A = 32'd0; bus.B = 32'd0;
    #1;
    check32("rst_busy", {31'd0, bus.busy}, 32'd0);
    check32("rst_hi", bus.HI, 32'd0);
    check32("rst_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(MDUOp_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(MDUOp_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(MDUOp_MULT,  32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(MDUOp_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(MDUOp_DIVU,  32'd7,         32'd0, 1'b0);
    run_op(MDUOp_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MDUOp_MTHI,  32'h1234_5678, 32'd0, 1'b0);
    run_op(MDUOp_MTLO,  32'hCAFE_F00D, 32'd0, 1'b0);
    run_op(4'd9,        32'hDEAD_BEEF, 32'd3, 1'b0);

    // start cancelled by req: nothing happens
    @(negedge clk);
    bus.start = 1'b1; bus.req = 1'b1; bus.MDUOp = MDUOp_MULT;
    bus.A = 32'd1234; bus.B = 32'd77;
    @(negedge clk);
    bus.start = 1'b0; bus.req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check32("cancel_busy", {31'd0, bus.busy}, 32'd0);
      check32("cancel_hi", bus.HI, m_hi);
      check32("cancel_lo", bus.LO, m_lo);
      @(negedge clk);
    end

    // second start during RUN is ignored; first result on time
    run_op(MDUOp_DIVU, 32'd1000, 32'd7, 1'b1);
    run_op(MDUOp_MULT, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1);

    // asynchronous reset in the middle of a DIV
    @(negedge clk);
    bus.start = 1'b1; bus.MDUOp = MDUOp_DIV; bus.A = 32'd100; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check32("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check32("midrst_hi", bus.HI, 32'd0);
    check32("midrst_lo", bus.LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check32("postrst_busy", {31'd0, bus.busy}, 32'd0);
    check32("postrst_hi", bus.HI, 32'd0);

    // random operations
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = MDUOp_MULT;
        1: op = MDUOp_MULTU;
        2: op = MDUOp_DIV;
        3: op = MDUOp_DIVU;
        4: op = MDUOp_MTHI;
        5: op = MDUOp_MTLO;
        6: op = 4'd11;
        default: op = MDUOp_NONE;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(16, 31);
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      run_op(op, a, b, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the pipelined MIPS core, the sequential counterpart to the combinational ALU in the EX stage. It accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` requests, holds the HI/LO architectural registers, and drives `busy` so the hazard unit stalls `mf*`/`mt*`/`md` instructions. It also honours the exception-cancel input so that a faulting or interrupted instruction never modifies HI/LO.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request valid in EX this cycle.
- `req`  in  1  exception/interrupt taken this cycle; cancels `start`.
- `MDUOp`  in  4  operation code (shared `MDUOp_*` constants).
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `busy`  out  1  operation in progress.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- States: IDLE, RUN.
- Reset: asynchronous, active-high. Forces state IDLE, counter 0, `busy`=0, HI=0, LO=0 immediately, regardless of clock. Reset during RUN discards the operation.
- Accepted request: `start`=1, `req`=0, state IDLE at a rising edge.
  - `start`=1 with `req`=1 is ignored: no state change, HI/LO untouched.
  - `start` in RUN is ignored. The pipeline guarantees this does not happen, and the bench still checks it.
- MULT: signed 32x32 -> 64-bit product, {HI,LO} = $signed(A)*$signed(B).
- MULTU: unsigned 32x32 -> 64-bit product, {HI,LO} = A*B.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient into LO, unsigned remainder into HI.
- Divide by zero (B=0): still enters RUN for DIV_CYCLES; HI/LO remain unchanged at completion.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: write A into HI or LO at the accepting edge. No RUN state, `busy` stays 0.
- Undefined MDUOp with `start`: treated as a no-op.
- Result is computed at the accepting edge into internal temp registers; HI/LO are written only on completion. This keeps visible HI/LO stable during RUN.

## Timing
- Accepting edge for mult/div: state goes to RUN, counter loads MULT_CYCLES or DIV_CYCLES, `busy`=1 from the next cycle.
- Each edge in RUN decrements the counter.
- At the edge where the counter reaches 1:
  - HI/LO load the temp result.
  - State returns to IDLE.
  - `busy` falls, so `busy` is high for exactly MULT_CYCLES/DIV_CYCLES cycles.
- Results are visible on HI/LO in the cycle `busy` first reads 0.
- MTHI/MTLO: HI/LO update at the accepting edge, visible the next cycle.
- The hazard unit uses (`busy` | `start` with an md opcode) for stalling. `start` is combinational to the stall logic, not inside this block.
- `busy` is a registered output and is never combinational from inputs.

## Structure
- Shared constants in `name.v`: `MDUOp_MULT`, `MDUOp_MULTU`, `MDUOp_DIV`, `MDUOp_DIVU`, `MDUOp_MTHI`, `MDUOp_MTLO`, `MDUOp_NONE`. These are 4-bit codes alongside the existing `ALUCtrl_*`.
- State encoding is a local 1-bit register. The counter is 4 bits, sized for DIV_CYCLES ≤ 15.
- No sub-module. The body consists of:
  - the product/quotient calculation into 64-bit temp registers,
  - the counter/FSM,
  - the HI/LO registers.

## Test plan
- MULT with A=0xFFFFFFFD (−3), B=5 -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. A MULT on the same operands yields HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV with A=0xFFFFFFF9 (−7), B=2 -> `busy` high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with A=7, B=0 -> `busy` 10 cycles; HI/LO keep their prior values.
- MTHI with A=0x12345678 -> HI=0x12345678 the next cycle, `busy` never asserted.
  - `start`=1 with `req`=1 and MDUOp=MULT -> `busy` stays 0, HI/LO unchanged.
- Start DIV, then assert `reset` mid-way (cycle 4, between clock edges) -> `busy`, HI, LO read 0 immediately.
  - A second `start` issued during RUN is ignored, and the first result is still delivered on time.
